// File: rtl/reg_wb_pkg.sv
// Shared widths and requester identifiers for the register-file writeback arbiter.
package reg_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant bit 0 is requester A, bit 1 is requester B.
module rr_arb2
  import reg_wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  req_e last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        grant_o = (last_q == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  // A grant is only ever given to a valid requester, so every grant is a completed transfer.
  always_comb begin
    last_d = last_q;
    if (grant_o[0]) begin
      last_d = REQ_A;
    end else if (grant_o[1]) begin
      last_d = REQ_B;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates two writeback requesters onto one registered register-file write port.
// Define WB_SCOREBOARD_EN to add the busy-register scoreboard for issue/hazard tracking.
module reg_wb_arbiter
  import reg_wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  A_valid_i,
  output logic                  A_ready_o,
  input  logic [REG_ADDR_W-1:0] A_addr_i,
  input  logic [XLEN-1:0]       A_data_i,
  input  logic                  B_valid_i,
  output logic                  B_ready_o,
  input  logic [REG_ADDR_W-1:0] B_addr_i,
  input  logic [XLEN-1:0]       B_data_i,
  output logic                  RegWrite_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic [XLEN-1:0]       RDdata_o,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic [REG_ADDR_W-1:0] RS1addr_i,
  input  logic [REG_ADDR_W-1:0] RS2addr_i,
  output logic                  hazard_o
);

  logic [1:0]            grant;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic                  wr_d, wr_q;
  logic [REG_ADDR_W-1:0] addr_d, addr_q;
  logic [XLEN-1:0]       data_d, data_q;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (!rst_i),
    .valid_i ({B_valid_i, A_valid_i}),
    .grant_o (grant)
  );

  assign A_ready_o = grant[0];
  assign B_ready_o = grant[1];

  always_comb begin
    xfer     = |grant;
    sel_addr = grant[1] ? B_addr_i : A_addr_i;
    sel_data = grant[1] ? B_data_i : A_data_i;
    // Writes to x0 are accepted but dropped; the port keeps its previous address/data.
    wr_d     = xfer && (sel_addr != '0);
    addr_d   = wr_d ? sel_addr : addr_q;
    data_d   = wr_d ? sel_data : data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RegWrite_o = wr_q;
  assign RDaddr_o   = addr_q;
  assign RDdata_o   = data_q;

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic                issue_fire;

  assign issue_ready_o = !busy_q[issue_rd_i];
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
  assign hazard_o      = busy_q[RS1addr_i] | busy_q[RS2addr_i];

  // Set is applied after clear so a same-cycle set/clear leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_issue;

  assign unused_issue  = ^{issue_valid_i, issue_rd_i, RS1addr_i, RS2addr_i};
  assign issue_ready_o = 1'b1;
  assign hazard_o      = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomised bench for reg_wb_arbiter against a transaction-level reference model.
module tb_reg_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        A_valid_i = 1'b0, B_valid_i = 1'b0;
  logic        A_ready_o, B_ready_o;
  logic [4:0]  A_addr_i = '0, B_addr_i = '0;
  logic [31:0] A_data_i = '0, B_data_i = '0;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic        issue_ready_o;
  logic [4:0]  RS1addr_i = '0, RS2addr_i = '0;
  logic        hazard_o;

  reg_wb_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .A_valid_i     (A_valid_i),
    .A_ready_o     (A_ready_o),
    .A_addr_i      (A_addr_i),
    .A_data_i      (A_data_i),
    .B_valid_i     (B_valid_i),
    .B_ready_o     (B_ready_o),
    .B_addr_i      (B_addr_i),
    .B_data_i      (B_data_i),
    .RegWrite_o    (RegWrite_o),
    .RDaddr_o      (RDaddr_o),
    .RDdata_o      (RDdata_o),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .RS1addr_i     (RS1addr_i),
    .RS2addr_i     (RS2addr_i),
    .hazard_o      (hazard_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Staged stimulus, applied to the DUT at the next falling edge.
  logic        s_av, s_bv, s_iv;
  logic [4:0]  s_aa, s_ba, s_ird, s_rs1, s_rs2;
  logic [31:0] s_ad, s_bd;

  // Reference model: what the write port should show, who won last, which regs are pending.
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        last_was_b;
  bit          busy [32];
  logic        last_ga, last_gb;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    last_was_b = 1'b1;
    foreach (busy[i]) busy[i] = 1'b0;
  endtask

  task automatic stage_idle();
    s_av = 0; s_bv = 0; s_iv = 0;
    s_aa = 0; s_ba = 0; s_ird = 0; s_rs1 = 0; s_rs2 = 0;
    s_ad = 0; s_bd = 0;
  endtask

  // One clock cycle: apply stimulus, compare every output with the model, advance the model.
  task automatic step();
    logic        ga, gb, exp_haz, exp_ir;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          nb [32];
    @(negedge clk_i);
    A_valid_i = s_av; A_addr_i = s_aa; A_data_i = s_ad;
    B_valid_i = s_bv; B_addr_i = s_ba; B_data_i = s_bd;
    issue_valid_i = s_iv; issue_rd_i = s_ird; RS1addr_i = s_rs1; RS2addr_i = s_rs2;
    #1;
    ga = s_av && (!s_bv || last_was_b);
    gb = s_bv && !ga;
`ifdef WB_SCOREBOARD_EN
    exp_haz = busy[s_rs1] || busy[s_rs2];
    exp_ir  = !busy[s_ird];
`else
    exp_haz = 1'b0;
    exp_ir  = 1'b1;
`endif
    check_eq("a_ready", A_ready_o, ga);
    check_eq("b_ready", B_ready_o, gb);
    check_eq("regwrite", RegWrite_o, exp_we);
    check_eq("rdaddr", RDaddr_o, exp_addr);
    check_eq("rddata", RDdata_o, exp_data);
    check_eq("hazard", hazard_o, exp_haz);
    check_eq("issue_ready", issue_ready_o, exp_ir);
    nb = busy;
    if (exp_we) nb[exp_addr] = 1'b0;
    if (s_iv && exp_ir && s_ird != 0) nb[s_ird] = 1'b1;
    busy = nb;
    wa = gb ? s_ba : s_aa;
    wd = gb ? s_bd : s_ad;
    if (ga || gb) last_was_b = gb;
    exp_we = (ga || gb) && (wa != 0);
    if (exp_we) begin
      exp_addr = wa;
      exp_data = wd;
    end
    last_ga = ga;
    last_gb = gb;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    stage_idle();
    A_valid_i = 0; B_valid_i = 0; issue_valid_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    stage_idle();
    model_reset();
    A_valid_i = 1'b1;
    A_addr_i  = 5'd3;
    @(posedge clk_i);
    #1;
    check_eq("rst_regwrite", RegWrite_o, 1'b0);
    check_eq("rst_rdaddr", RDaddr_o, 5'd0);
    check_eq("rst_rddata", RDdata_o, 32'd0);
    check_eq("rst_a_ready", A_ready_o, 1'b0);
    check_eq("rst_hazard", hazard_o, 1'b0);
    apply_reset();

    // Single A write right after reset.
    s_av = 1; s_aa = 5'd5; s_ad = 32'h1234;
    step();
    check_eq("r029_a_ready", A_ready_o, 1'b1);
    stage_idle();
    step();
    check_eq("r029_we", RegWrite_o, 1'b1);
    check_eq("r029_addr", RDaddr_o, 5'd5);
    check_eq("r029_data", RDdata_o, 32'h1234);

    // Continuous contention alternates starting with A from a fresh pointer.
    apply_reset();
    s_av = 1; s_aa = 5'd1; s_ad = 32'hA0;
    s_bv = 1; s_ba = 5'd2; s_bd = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("r030_grant", {30'd0, last_ga, last_gb}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (last_ga) begin s_aa = s_aa + 5'd2; s_ad = s_ad + 32'd1; end
      if (last_gb) begin s_ba = s_ba + 5'd2; s_bd = s_bd + 32'd1; end
    end
    stage_idle();
    step();
    check_eq("r030_last_we", RegWrite_o, 1'b1);

    // Write to x0 is accepted but never reaches the register file.
    stage_idle();
    s_bv = 1; s_ba = 5'd0; s_bd = 32'hFFFF_FFFF;
    step();
    check_eq("r031_b_ready", B_ready_o, 1'b1);
    stage_idle();
    step();
    check_eq("r031_we", RegWrite_o, 1'b0);

    // Issue reservation and hazard on rd 7.
    stage_idle();
    s_iv = 1; s_ird = 5'd7;
    step();
    s_iv = 0; s_rs1 = 5'd7;
    step();
`ifdef WB_SCOREBOARD_EN
    check_eq("r032_hazard", hazard_o, 1'b1);
    check_eq("r032_issue_ready", issue_ready_o, 1'b0);
    s_bv = 1; s_ba = 5'd7; s_bd = 32'h77;
    step();
    s_bv = 0;
    step();
    check_eq("r032_we", RegWrite_o, 1'b1);
    step();
    check_eq("r032_hazard_clr", hazard_o, 1'b0);
`else
    check_eq("r034_hazard", hazard_o, 1'b0);
    check_eq("r034_issue_ready", issue_ready_o, 1'b1);
`endif

    // Random traffic; unaccepted requests are held stable until granted.
    stage_idle();
    for (int i = 0; i < 400; i++) begin
      if (!(s_av && !last_ga) || i == 0) begin
        s_av = ($urandom_range(0, 2) != 0);
        s_aa = rand_addr();
        s_ad = $urandom;
      end
      if (!(s_bv && !last_gb) || i == 0) begin
        s_bv = ($urandom_range(0, 2) != 0);
        s_ba = rand_addr();
        s_bd = $urandom;
      end
      s_iv  = ($urandom_range(0, 3) == 0);
      s_ird = rand_addr();
      s_rs1 = 5'($urandom_range(0, 31));
      s_rs2 = 5'($urandom_range(0, 31));
      step();
    end

    // Reset right after a transfer discards the pending write and the scoreboard.
    stage_idle();
    s_av = 1; s_aa = 5'd9; s_ad = 32'hDEAD; s_iv = 1; s_ird = 5'd9;
    step();
    @(posedge clk_i);
    #1;
    check_eq("r033_pre_we", RegWrite_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check_eq("r033_we_now", RegWrite_o, 1'b0);
    check_eq("r033_a_ready", A_ready_o, 1'b0);
    apply_reset();
    s_rs1 = 5'd9;
    step();
    check_eq("r033_no_we", RegWrite_o, 1'b0);
    check_eq("r033_busy_clr", hazard_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
